// File: rtl/lcd_bus_sequencer_if.sv
// rtl/lcd_bus_sequencer_if.sv - Avalon-MM register port of the LCD bus sequencer
interface lcd_bus_sequencer_if;
  logic [1:0] address;
  logic       read;
  logic       write;
  logic [7:0] writedata;
  logic [7:0] readdata;
  logic       waitrequest;

  modport master (
    output address, read, write, writedata,
    input  readdata, waitrequest
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, waitrequest
  );
endinterface

// File: rtl/lcd_bus_sequencer.sv
// rtl/lcd_bus_sequencer.sv - timed HD44780 E/RS/RW cycle sequencer with busy-flag polling
// Stalls the Avalon master with waitrequest until the full LCD cycle (and any polls) has finished.
module lcd_bus_sequencer #(
  parameter int SETUP_CYC    = 3,
  parameter int E_HIGH_CYC   = 12,
  parameter int HOLD_CYC     = 1,
  parameter int RECOVER_CYC  = 10,
  parameter int POLL_BUSY    = 1,
  parameter int BUSY_TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  lcd_bus_sequencer_if.slave bus,
  output logic               busy_timeout,
  output logic               LCD_E,
  output logic               LCD_RS,
  output logic               LCD_RW,
  inout  wire  [7:0]         LCD_data
);

  // Zero-valued timing parameters behave as one cycle.
  localparam logic [15:0] SETUP_LAST   = 16'((SETUP_CYC   < 1 ? 1 : SETUP_CYC)   - 1);
  localparam logic [15:0] EHI_LAST     = 16'((E_HIGH_CYC  < 1 ? 1 : E_HIGH_CYC)  - 1);
  localparam logic [15:0] HOLD_LAST    = 16'((HOLD_CYC    < 1 ? 1 : HOLD_CYC)    - 1);
  localparam logic [15:0] RECOVER_LAST = 16'((RECOVER_CYC < 1 ? 1 : RECOVER_CYC) - 1);
  localparam logic [15:0] POLL_MAX     = 16'(BUSY_TIMEOUT < 1 ? 1 : BUSY_TIMEOUT);

  typedef enum logic [3:0] {
    IDLE, SETUP, EHI, HOLD, POLL_SETUP, POLL_EHI, POLL_HOLD, RECOVER, DONE
  } state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] polls;
  logic        op_write;
  logic [7:0]  lat_data;
  logic        drive_en;
  logic        db7;
  logic        term;

  // address[0] is implied by the strobe: writes always use RW=0, reads RW=1.
  wire unused_rw_bit = bus.address[0];

  assign bus.waitrequest = (bus.read | bus.write) & (state != DONE);
  assign LCD_data        = drive_en ? lat_data : 8'bz;

  always_comb begin
    term = 1'b1;
    case (state)
      SETUP, POLL_SETUP: term = (cnt >= SETUP_LAST);
      EHI, POLL_EHI:     term = (cnt >= EHI_LAST);
      HOLD, POLL_HOLD:   term = (cnt >= HOLD_LAST);
      RECOVER:           term = (cnt >= RECOVER_LAST);
      default:           term = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 16'd0;
      polls        <= 16'd0;
      op_write     <= 1'b0;
      lat_data     <= 8'd0;
      drive_en     <= 1'b0;
      db7          <= 1'b0;
      LCD_E        <= 1'b0;
      LCD_RS       <= 1'b0;
      LCD_RW       <= 1'b1;
      bus.readdata <= 8'd0;
      busy_timeout <= 1'b0;
    end else begin
      cnt <= term ? 16'd0 : ((cnt == 16'hFFFF) ? cnt : cnt + 16'd1);
      case (state)
        IDLE: begin
          if (bus.read || bus.write) begin
            state    <= SETUP;
            op_write <= ~bus.read;
            lat_data <= bus.writedata;
            polls    <= 16'd0;
            LCD_E    <= 1'b0;
            LCD_RS   <= bus.address[1];
            LCD_RW   <= bus.read;
            drive_en <= ~bus.read;
            if (!bus.read) busy_timeout <= 1'b0;
          end
        end
        SETUP: if (term) begin
          state <= EHI;
          LCD_E <= 1'b1;
        end
        EHI: if (term) begin
          state <= HOLD;
          LCD_E <= 1'b0;
          if (!op_write) bus.readdata <= LCD_data;
        end
        HOLD: if (term) begin
          drive_en <= 1'b0;
          LCD_RS   <= 1'b0;
          LCD_RW   <= 1'b1;
          state    <= (op_write && POLL_BUSY != 0) ? POLL_SETUP : RECOVER;
        end
        POLL_SETUP: if (term) begin
          state <= POLL_EHI;
          LCD_E <= 1'b1;
        end
        POLL_EHI: if (term) begin
          state <= POLL_HOLD;
          LCD_E <= 1'b0;
          db7   <= LCD_data[7];
        end
        POLL_HOLD: if (term) begin
          if (!db7) begin
            state <= RECOVER;
          end else if (polls < POLL_MAX) begin
            polls <= (polls == 16'hFFFF) ? polls : polls + 16'd1;
            state <= POLL_SETUP;
          end else begin
            busy_timeout <= 1'b1;
            state        <= RECOVER;
          end
        end
        RECOVER: if (term) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// tb/tb_lcd_bus_sequencer.sv - scoreboard bench for lcd_bus_sequencer
// Three instances: defaults, BUSY_TIMEOUT=2, POLL_BUSY=0; sel routes the shared stimulus.
module tb_lcd_bus_sequencer;

  typedef struct {
    int         lat;
    int         pulses;
    logic [9:0] sig;
    logic       is_rd;
    logic [7:0] rdata;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] sel;
  logic [1:0] addr;
  logic       rd, wr;
  logic [7:0] wd;
  logic [7:0] rdval;
  int         busy_n;
  int         poll_falls;
  int         probe_id, probe_kind, probe_seen;
  int         n_cmp, n_bad;
  exp_t       sb[$];

  wire [2:0]      e_v, rs_v, rw_v, wq_v, to_v;
  wire [2:0][7:0] rdd_v, bus_v;
  wire [7:0]      status = {(poll_falls < busy_n), 7'h2A};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    lcd_bus_sequencer_if bus();
    wire [7:0] lcd_data;
    logic      e, rs, rw, to;

    assign bus.address   = addr;
    assign bus.read      = rd && (sel == 2'(g));
    assign bus.write     = wr && (sel == 2'(g));
    assign bus.writedata = wd;

    lcd_bus_sequencer #(
      .BUSY_TIMEOUT(g == 1 ? 2 : 4096),
      .POLL_BUSY   (g == 2 ? 0 : 1)
    ) dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .busy_timeout(to),
      .LCD_E       (e),
      .LCD_RS      (rs),
      .LCD_RW      (rw),
      .LCD_data    (lcd_data)
    );

    // LCD model drives the bus whenever the controller reads.
    assign lcd_data = rw ? (rs ? rdval : status) : 8'bz;

    assign e_v[g]   = e;
    assign rs_v[g]  = rs;
    assign rw_v[g]  = rw;
    assign wq_v[g]  = bus.waitrequest;
    assign to_v[g]  = to;
    assign rdd_v[g] = bus.readdata;
    assign bus_v[g] = lcd_data;
  end

  wire       e_s   = e_v[sel];
  wire       rs_s  = rs_v[sel];
  wire       rw_s  = rw_v[sel];
  wire       wq_s  = wq_v[sel];
  wire       to_s  = to_v[sel];
  wire [7:0] rdd_s = rdd_v[sel];
  wire [7:0] bus_s = bus_v[sel];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: tracks the pin activity of each transfer and compares at completion.
  int   cyc, pulses, rise, werr, wcur, perr;
  logic in_txn, eprev;
  exp_t x;

  initial begin
    n_cmp = 0; n_bad = 0; probe_seen = 0; in_txn = 1'b0; eprev = 1'b0; poll_falls = 0;
    cyc = 0; pulses = 0; rise = -1; werr = 0; wcur = 0; perr = 0;
  end

  always @(negedge clk) begin
    if (probe_id != probe_seen) begin
      probe_seen = probe_id;
      if (probe_kind == 1) begin
        chk("rst_lcd_e", e_s, 0);
        chk("rst_lcd_rw", rw_s, 1);
        chk("rst_lcd_rs", rs_s, 0);
        chk("rst_readdata", rdd_s, 0);
        chk("rst_busy_timeout", to_s, 0);
        chk("rst_waitrequest", wq_s, 0);
        chk("rst_bus_released", bus_s, 8'h2A);
      end else begin
        chk("scoreboard_empty", sb.size(), 0);
      end
    end
    if (reset || !(rd || wr)) begin
      in_txn = 1'b0;
    end else begin
      if (!in_txn) begin
        in_txn = 1'b1; cyc = 0; pulses = 0; rise = -1;
        werr = 0; wcur = 0; perr = 0; poll_falls = 0; eprev = 1'b0;
      end else begin
        cyc++;
      end
      if (e_s && !eprev) begin
        if (pulses == 0) rise = cyc;
        pulses++;
      end
      if (e_s) begin
        wcur++;
      end else if (eprev) begin
        if (wcur != 12) werr++;
        if (rw_s && !rs_s) poll_falls++;
        wcur = 0;
      end
      if (cyc >= 1 && cyc <= 16 && sb.size() > 0)
        if ({rs_s, rw_s, bus_s} != sb[0].sig) perr++;
      eprev = e_s;
      if (!wq_s) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("latency", cyc + 1, x.lat);
          chk("e_pulses", pulses, x.pulses);
          chk("e_rise_cycle", rise, 4);
          chk("e_width_errs", werr, 0);
          chk("bus_phase_errs", perr, 0);
          chk("busy_timeout", to_s, x.to);
          if (x.is_rd) chk("readdata", rdd_s, x.rdata);
        end
        in_txn = 1'b0;
      end
    end
  end

  task automatic xfer(input logic [1:0] s, input logic is_rd, input logic [1:0] a,
                      input logic [7:0] d, input int bn, input logic [7:0] bexp,
                      input int lat, input int np, input logic to, input logic [7:0] rexp);
    exp_t t;
    sel = s; busy_n = bn;
    t.lat = lat; t.pulses = np; t.sig = {a[1], is_rd, bexp};
    t.is_rd = is_rd; t.rdata = rexp; t.to = to;
    sb.push_back(t);
    addr = a; wd = d; rd = is_rd; wr = ~is_rd;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!wq_s) break;
    end
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic probe(input int kind);
    probe_kind = kind;
    probe_id   = probe_id + 1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; sel = 2'd0; addr = 2'd0; rd = 1'b0; wr = 1'b0; wd = 8'd0;
    rdval = 8'h41; busy_n = 0; probe_id = 0; probe_kind = 0;
    repeat (3) @(posedge clk);
    #1;
    probe(1);
    reset = 1'b0;
    @(posedge clk); #1;

    //   sel rd  addr  data   busy  bus    lat pul to    rdata
    xfer(0, 0, 2'd0, 8'h38, 0,    8'h38, 44, 2,  1'b0, 8'h00);
    xfer(0, 1, 2'd3, 8'hA5, 0,    8'h41, 28, 1,  1'b0, 8'h41);
    xfer(0, 0, 2'd0, 8'h01, 3,    8'h01, 92, 5,  1'b0, 8'h00);
    xfer(0, 1, 2'd1, 8'hFF, 0,    8'h2A, 28, 1,  1'b0, 8'h2A);
    xfer(1, 0, 2'd2, 8'h80, 1000, 8'h80, 76, 4,  1'b1, 8'h00);
    xfer(1, 1, 2'd3, 8'h00, 0,    8'h41, 28, 1,  1'b1, 8'h41);
    xfer(1, 0, 2'd0, 8'h06, 0,    8'h06, 44, 2,  1'b0, 8'h00);
    xfer(2, 0, 2'd1, 8'hC0, 1000, 8'hC0, 28, 1,  1'b0, 8'h00);

    // Abort a write while E is high.
    sel = 2'd0; busy_n = 0; addr = 2'd0; wd = 8'h5A; wr = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (e_s) break;
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; wr = 1'b0;
    @(posedge clk); #1;
    probe(1);
    reset = 1'b0;
    @(posedge clk); #1;
    rdval = 8'h7E;
    xfer(0, 1, 2'd3, 8'h81, 0, 8'h7E, 28, 1, 1'b0, 8'h7E);

    probe(2);
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
